// File: rtl/gen_add_pkg.sv
// Shared definitions for the chunked wide-add sequencer.
// Holds the FSM state encoding and the index-counter width helper.
package gen_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A counter for one chunk still needs one bit.
    function automatic int idx_width(input int k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/gen_case_add.sv
// N-bit ripple adder built from a per-bit full-adder truth table.
// This is the shared chunk datapath for the wide-add sequencer.
module gen_case_add #(
    parameter int N = 4
) (
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic         carry_in,
    output logic [N-1:0] sum,
    output logic         carry_out
);

    logic c;

    always_comb begin
        sum = '0;
        c   = carry_in;
        for (int i = 0; i < N; i++) begin
            case ({in1[i], in2[i], c})
                3'b000: begin sum[i] = 1'b0; c = 1'b0; end
                3'b001: begin sum[i] = 1'b1; c = 1'b0; end
                3'b010: begin sum[i] = 1'b1; c = 1'b0; end
                3'b011: begin sum[i] = 1'b0; c = 1'b1; end
                3'b100: begin sum[i] = 1'b1; c = 1'b0; end
                3'b101: begin sum[i] = 1'b0; c = 1'b1; end
                3'b110: begin sum[i] = 1'b0; c = 1'b1; end
                default: begin sum[i] = 1'b1; c = 1'b1; end
            endcase
        end
        carry_out = c;
    end

endmodule

// File: rtl/gen_add_seq_ctrl.sv
// Adds two N*K-bit operands over K cycles through one shared N-bit adder,
// LSB chunk first, with a start/ready/done handshake to the requester.
module gen_add_seq_ctrl
    import gen_add_pkg::*;
#(
    parameter int N = 4,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N*K-1:0] a,
    input  logic [N*K-1:0] b,
    input  logic           cin,
    output logic           ready,
    output logic           done,
    output logic [N*K-1:0] result,
    output logic           cout
);

    localparam int W  = N * K;
    localparam int IW = idx_width(K);

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [W-1:0]   acc;
    logic [W-1:0]   acc_nxt;
    logic           carry_q;
    logic [IW-1:0]  idx;
    logic [N-1:0]   chunk_sum;
    logic           chunk_cout;
    logic           last;

    assign last = (idx == IW'(K - 1));

    gen_case_add #(.N(N)) u_add (
        .in1       (op_a[idx*N +: N]),
        .in2       (op_b[idx*N +: N]),
        .carry_in  (carry_q),
        .sum       (chunk_sum),
        .carry_out (chunk_cout)
    );

    // Accumulator with the current chunk merged in; on the last chunk this is
    // the final sum, so result can load it on the same edge that enters DONE.
    always_comb begin
        acc_nxt = acc;
        acc_nxt[idx*N +: N] = chunk_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a    <= '0;
            op_b    <= '0;
            acc     <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            result  <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a    <= a;
                        op_b    <= b;
                        carry_q <= cin;
                        acc     <= '0;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    acc     <= acc_nxt;
                    carry_q <= chunk_cout;
                    if (last) begin
                        idx    <= '0;
                        result <= acc_nxt;
                        cout   <= chunk_cout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
